dphy_lane_tx: RTL and testbench



---
 rtl/dphy_lane_tx_if.sv | 27 ++
 rtl/dphy_lane_tx.sv | 166 ++++++++++++++++
 tb/tb_dphy_lane_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dphy_lane_tx_if.sv
// Packet word stream feeding the D-PHY lane distributor.
// The master drives the words and the slave returns ready.
interface dphy_lane_tx_if #(
    parameter int DATA_LANES = 4
);
    logic [DATA_LANES*8-1:0] word_i;
    logic                    word_valid_i;
    logic                    word_last_i;
    logic [DATA_LANES-1:0]   word_keep_i;
    logic                    word_ready_o;

    modport master (
        output word_i,
        output word_valid_i,
        output word_last_i,
        output word_keep_i,
        input  word_ready_o
    );

    modport slave (
        input  word_i,
        input  word_valid_i,
        input  word_last_i,
        input  word_keep_i,
        output word_ready_o
    );
endinterface

// File: rtl/dphy_lane_tx.sv
// D-PHY transmit lane distributor: HS-zero prepare, 0xB8 sync, payload and HS-trail on every lane.
// Each registered output reflects the state of the previous cycle, so all lanes move in lockstep.
module dphy_lane_tx #(
    parameter int DATA_LANES   = 4,
    parameter int PREP_CYCLES  = 3,
    parameter int TRAIL_CYCLES = 2
) (
    input  logic                    byte_clk_i,
    input  logic                    rst_i,
    dphy_lane_tx_if.slave           word_if,
    output logic                    hs_req_o,
    output logic [DATA_LANES*8-1:0] byte_data_o,
    output logic [DATA_LANES-1:0]   valid_o,
    output logic                    underflow_o,
    output logic                    busy_o
);

    localparam int MAX_CYC = (PREP_CYCLES > TRAIL_CYCLES) ? PREP_CYCLES : TRAIL_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] PREP_LOAD  = CW'(PREP_CYCLES - 1);
    localparam logic [CW-1:0] TRAIL_LOAD = CW'(TRAIL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SYNC,
        DATA,
        TRAIL,
        GAP
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_LANES-1:0]   lastBit_q, lastBit_d;
    logic                    hsReq_q, hsReq_d;
    logic [DATA_LANES*8-1:0] byteData_q, byteData_d;
    logic [DATA_LANES-1:0]   valid_q, valid_d;
    logic                    underflow_q, underflow_d;
    logic                    busy_q, busy_d;
    logic [DATA_LANES-1:0]   keepEff;
    logic                    accept;

    assign keepEff              = word_if.word_keep_i | DATA_LANES'(1);
    assign accept               = (state_q == DATA) && word_if.word_valid_i;
    assign word_if.word_ready_o = (state_q == DATA);

    assign hs_req_o    = hsReq_q;
    assign byte_data_o = byteData_q;
    assign valid_o     = valid_q;
    assign underflow_o = underflow_q;
    assign busy_o      = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (word_if.word_valid_i) begin
                    state_d = PREP;
                    cnt_d   = PREP_LOAD;
                end
            end
            PREP: begin
                if (cnt_q == '0) begin
                    state_d = SYNC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SYNC: state_d = DATA;
            DATA: begin
                if (accept && word_if.word_last_i) begin
                    state_d = TRAIL;
                    cnt_d   = TRAIL_LOAD;
                end
            end
            TRAIL: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                // A waiting packet skips IDLE so the LP gap stays exactly one cycle.
                if (word_if.word_valid_i) begin
                    state_d = PREP;
                    cnt_d   = PREP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hsReq_d     = 1'b0;
        byteData_d  = byteData_q;
        valid_d     = '0;
        underflow_d = 1'b0;
        lastBit_d   = lastBit_q;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE: byteData_d = '0;
            PREP: begin
                hsReq_d    = 1'b1;
                byteData_d = '0;
            end
            SYNC: begin
                hsReq_d    = 1'b1;
                byteData_d = {DATA_LANES{8'hB8}};
                valid_d    = '1;
                lastBit_d  = '1;
            end
            DATA: begin
                hsReq_d = 1'b1;
                if (word_if.word_valid_i) begin
                    // Lanes dropped from the last word start their trail immediately.
                    for (int i = 0; i < DATA_LANES; i++) begin
                        if (!word_if.word_last_i || keepEff[i]) begin
                            byteData_d[i*8 +: 8] = word_if.word_i[i*8 +: 8];
                            valid_d[i]           = 1'b1;
                            lastBit_d[i]         = word_if.word_i[i*8+7];
                        end else begin
                            byteData_d[i*8 +: 8] = {8{~lastBit_q[i]}};
                        end
                    end
                end else begin
                    underflow_d = 1'b1;
                end
            end
            TRAIL: begin
                hsReq_d = 1'b1;
                for (int i = 0; i < DATA_LANES; i++) begin
                    byteData_d[i*8 +: 8] = {8{~lastBit_q[i]}};
                end
            end
            GAP: byteData_d = '0;
            default: byteData_d = '0;
        endcase
    end

    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lastBit_q   <= '0;
            hsReq_q     <= 1'b0;
            byteData_q  <= '0;
            valid_q     <= '0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastBit_q   <= lastBit_d;
            hsReq_q     <= hsReq_d;
            byteData_q  <= byteData_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dphy_lane_tx.sv
// Directed bench for dphy_lane_tx with 4 lanes, PREP_CYCLES=3, TRAIL_CYCLES=2.
// A per-cycle vector table covers whole packets; hand sequences cover back-to-back and keep=0000.
module tb_dphy_lane_tx;

    localparam logic [31:0] W0    = 32'h03020100;
    localparam logic [31:0] W1    = 32'h07060504;
    localparam logic [31:0] W2    = 32'h0B0A0908;
    localparam logic [31:0] WS    = 32'h00C0C180;
    localparam logic [31:0] SYNCW = 32'hB8B8B8B8;
    localparam logic [31:0] ONES  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsReq;
    logic [31:0] byteData;
    logic [3:0]  laneValid;
    logic        underflow;
    logic        busy;
    int          checkCount = 0;
    int          passCount  = 0;

    dphy_lane_tx_if #(.DATA_LANES(4)) wordIf ();

    dphy_lane_tx #(
        .DATA_LANES  (4),
        .PREP_CYCLES (3),
        .TRAIL_CYCLES(2)
    ) dut (
        .byte_clk_i (clk),
        .rst_i      (rst),
        .word_if    (wordIf),
        .hs_req_o   (hsReq),
        .byte_data_o(byteData),
        .valid_o    (laneValid),
        .underflow_o(underflow),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          grp;
        logic        rst;
        logic        vld;
        logic        last;
        logic [3:0]  keep;
        logic [31:0] word;
        logic        expRdy;
        logic        expHs;
        logic [31:0] expData;
        logic [3:0]  expValid;
        logic        expUf;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input int grp, input logic r, input logic v, input logic l,
                          input logic [3:0] k, input logic [31:0] w,
                          input logic er, input logic eh, input logic [31:0] ed,
                          input logic [3:0] ev, input logic eu, input logic eb);
        vec_t t;
        t.grp = grp;  t.rst = r;  t.vld = v;  t.last = l;  t.keep = k;  t.word = w;
        t.expRdy = er;  t.expHs = eh;  t.expData = ed;  t.expValid = ev;
        t.expUf = eu;  t.expBusy = eb;
        vecs.push_back(t);
    endtask

    // Five cycles from IDLE with a word waiting: IDLE, three PREP cycles, SYNC.
    task automatic addPrep(input int grp, input logic [31:0] w);
        addVec(grp, 0, 1, 0, 4'h0, w, 0, 0, 32'h0, 4'h0, 0, 0);
        addVec(grp, 0, 1, 0, 4'h0, w, 0, 0, 32'h0, 4'h0, 0, 1);
        addVec(grp, 0, 1, 0, 4'h0, w, 0, 1, 32'h0, 4'h0, 0, 1);
        addVec(grp, 0, 1, 0, 4'h0, w, 0, 1, 32'h0, 4'h0, 0, 1);
        addVec(grp, 0, 1, 0, 4'h0, w, 0, 1, 32'h0, 4'h0, 0, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst                 = v.rst;
        wordIf.word_valid_i = v.vld;
        wordIf.word_last_i  = v.last;
        wordIf.word_keep_i  = v.keep;
        wordIf.word_i       = v.word;
    endtask

    task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got {rdy,hs,data,valid,uf,busy}=%h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [39:0] dutOutputs();
        return {wordIf.word_ready_o, hsReq, byteData, laneValid, underflow, busy};
    endfunction

    task automatic driveWord(input logic v, input logic l, input logic [3:0] k, input logic [31:0] w);
        wordIf.word_valid_i = v;
        wordIf.word_last_i  = l;
        wordIf.word_keep_i  = k;
        wordIf.word_i       = w;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        int lowCount;

        rst = 1'b1;
        driveWord(0, 0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset state", dutOutputs(), 40'h0);

        // Group 1: three-word packet with full keep.
        addPrep(1, W0);
        addVec(1, 0, 1, 0, 4'h0, W0,    1, 1, SYNCW, 4'hF, 0, 1);
        addVec(1, 0, 1, 0, 4'h0, W1,    1, 1, W0,    4'hF, 0, 1);
        addVec(1, 0, 1, 1, 4'hF, W2,    1, 1, W1,    4'hF, 0, 1);
        addVec(1, 0, 0, 0, 4'h0, 32'h0, 0, 1, W2,    4'hF, 0, 1);
        addVec(1, 0, 0, 0, 4'h0, 32'h0, 0, 1, ONES,  4'h0, 0, 1);
        addVec(1, 0, 0, 0, 4'h0, 32'h0, 0, 1, ONES,  4'h0, 0, 1);
        addVec(1, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        addVec(1, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0);

        // Group 2: short last word, keep 0011.
        addPrep(2, W0);
        addVec(2, 0, 1, 0, 4'h0, W0,    1, 1, SYNCW,        4'hF, 0, 1);
        addVec(2, 0, 1, 1, 4'h3, WS,    1, 1, W0,           4'hF, 0, 1);
        addVec(2, 0, 0, 0, 4'h0, 32'h0, 0, 1, 32'hFFFFC180, 4'h3, 0, 1);
        addVec(2, 0, 0, 0, 4'h0, 32'h0, 0, 1, 32'hFFFF0000, 4'h0, 0, 1);
        addVec(2, 0, 0, 0, 4'h0, 32'h0, 0, 1, 32'hFFFF0000, 4'h0, 0, 1);
        addVec(2, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0,        4'h0, 0, 0);

        // Group 3: two-cycle starvation between the first and second words.
        addPrep(3, W0);
        addVec(3, 0, 1, 0, 4'h0, W0,    1, 1, SYNCW, 4'hF, 0, 1);
        addVec(3, 0, 0, 0, 4'h0, 32'h0, 1, 1, W0,    4'hF, 0, 1);
        addVec(3, 0, 0, 0, 4'h0, 32'h0, 1, 1, W0,    4'h0, 1, 1);
        addVec(3, 0, 1, 0, 4'h0, W1,    1, 1, W0,    4'h0, 1, 1);
        addVec(3, 0, 1, 1, 4'hF, W2,    1, 1, W1,    4'hF, 0, 1);
        addVec(3, 0, 0, 0, 4'h0, 32'h0, 0, 1, W2,    4'hF, 0, 1);
        addVec(3, 0, 0, 0, 4'h0, 32'h0, 0, 1, ONES,  4'h0, 0, 1);
        addVec(3, 0, 0, 0, 4'h0, 32'h0, 0, 1, ONES,  4'h0, 0, 1);
        addVec(3, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0);

        // Group 4: reset in the second DATA cycle, then a clean one-word packet.
        addPrep(4, W0);
        addVec(4, 0, 1, 0, 4'h0, W0,    1, 1, SYNCW, 4'hF, 0, 1);
        addVec(4, 1, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        addPrep(4, W0);
        addVec(4, 0, 1, 1, 4'hF, W0,    1, 1, SYNCW, 4'hF, 0, 1);
        addVec(4, 0, 0, 0, 4'h0, 32'h0, 0, 1, W0,    4'hF, 0, 1);
        addVec(4, 0, 0, 0, 4'h0, 32'h0, 0, 1, ONES,  4'h0, 0, 1);
        addVec(4, 0, 0, 0, 4'h0, 32'h0, 0, 1, ONES,  4'h0, 0, 1);
        addVec(4, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d grp%0d", i, vecs[i].grp), dutOutputs(),
                        {vecs[i].expRdy, vecs[i].expHs, vecs[i].expData,
                         vecs[i].expValid, vecs[i].expUf, vecs[i].expBusy});
        end

        // Keep 0000 on a one-word packet behaves as keep 0001.
        driveWord(1, 1, 4'h0, 32'h44332211);
        n = 0;
        sampleCycle();
        while (!wordIf.word_ready_o && n < 20) begin
            sampleCycle();
            n++;
        end
        checkOutput("keep0 ready", {39'h0, wordIf.word_ready_o}, 40'h1);
        @(posedge clk);
        #1;
        driveWord(0, 0, 4'h0, 32'h0);
        sampleCycle();
        checkOutput("keep0 data", dutOutputs(), {1'b0, 1'b1, 32'h00000011, 4'h1, 1'b0, 1'b1});
        sampleCycle();
        checkOutput("keep0 trail1", dutOutputs(), {1'b0, 1'b1, 32'h000000FF, 4'h0, 1'b0, 1'b1});
        sampleCycle();
        checkOutput("keep0 trail2", dutOutputs(), {1'b0, 1'b1, 32'h000000FF, 4'h0, 1'b0, 1'b1});
        sampleCycle();
        checkOutput("keep0 gap", dutOutputs(), 40'h0);
        repeat (2) sampleCycle();

        // Back-to-back: valid held through GAP gives a single hs_req low cycle.
        driveWord(1, 1, 4'hF, W0);
        n = 0;
        sampleCycle();
        while (!hsReq && n < 20) begin
            sampleCycle();
            n++;
        end
        checkOutput("b2b first hs rise", {39'h0, hsReq}, 40'h1);
        n = 0;
        while (hsReq && n < 20) begin
            sampleCycle();
            n++;
        end
        checkOutput("b2b first hs fall", {39'h0, hsReq}, 40'h0);
        checkOutput("b2b busy in gap", {39'h0, busy}, 40'h1);
        lowCount = 0;
        while (!hsReq && lowCount < 10) begin
            sampleCycle();
            lowCount++;
        end
        checkOutput("b2b hs low cycles", 40'(lowCount), 40'd1);
        n = 0;
        while (laneValid == 4'h0 && n < 20) begin
            sampleCycle();
            n++;
        end
        checkOutput("b2b second sync", {byteData, laneValid}, {SYNCW, 4'hF});
        @(posedge clk);
        #1;
        driveWord(0, 0, 4'h0, 32'h0);
        repeat (10) sampleCycle();
        checkOutput("b2b drained", dutOutputs(), 40'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
